display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL provide port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port enable  input  1  1 = scan digits; 0 = display dark, scan held.
REQ-005 SHALL provide port load  input  1  one-cycle strobe; capture data_in.
REQ-006 SHALL provide port data_in  input  32  eight hex nibbles; nibble k, bits 4k+3..4k, shown on digit k.
REQ-007 SHALL provide port anode  output  8  active-low digit selects; bit k drives digit k.
REQ-008 SHALL provide port hex_sel  output  4  nibble for the active digit; feeds the seven-segment decoder.
REQ-009 SHALL provide port blank  output  1  1 = force all cathodes off, including dp.
REQ-010 SHALL provide port digit_idx  output  3  index of the active digit.
REQ-011 SHALL provide port frame_done  output  1  one-cycle pulse on 7->0 digit wrap.

Function
REQ-012 SHALL count tick_cnt 0..REFRESH_DIV-1 while enable=1; terminal count SHALL generate an internal tick and return tick_cnt to 0.
REQ-013 SHALL advance digit_idx by 1 on each tick, wrapping 7->0.
REQ-014 SHALL assert frame_done for exactly the cycle after the tick that wraps digit_idx 7->0.
REQ-015 SHALL register anode, hex_sel and blank so they change one cycle after digit_idx changes. The lag is fixed at 1 cycle.
REQ-016 SHALL drive anode = ~(1 << digit_idx) when enable=1, so exactly one bit is low; otherwise anode = 8'hFF.
REQ-017 SHALL drive hex_sel = active nibble at digit_idx, taken from the active display register.
REQ-018 SHALL capture data_in into a shadow register on load=1 and set pending=1.
REQ-019 SHALL copy shadow to the active register and clear pending at the frame wrap. Update is tear-free; no mid-frame change.
REQ-020 If load and frame wrap occur on the same cycle, the active register SHALL take data_in directly and pending SHALL end at 0.
REQ-021 Repeated loads within one frame SHALL keep only the last value.
REQ-022 On enable 1->0: tick_cnt, digit_idx SHALL return to 0 next cycle. Also next cycle: anode=8'hFF, blank=1, no frame_done. Load capture SHALL continue.
REQ-023 While enable=0, pending data SHALL transfer to the active register immediately on the next cycle.
REQ-024 On enable 0->1, the scan SHALL restart at digit 0 with a full REFRESH_DIV slot.

Reset
REQ-025 reset_n=0 SHALL immediately set outputs and state, independent of clk. Outputs: anode=8'hFF, blank=1, hex_sel=0, digit_idx=0, frame_done=0. State: tick_cnt=0, shadow=0, active=0, pending=0.
REQ-026 Reset assertion mid-slot or mid-frame SHALL discard pending data. Scanning SHALL resume at digit 0 on the first clk edge after release with enable=1.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking. When defined, blank=1 for every digit above the most significant nonzero active nibble. Digit 0 SHALL never be blanked this way; value 0 shows a single "0".
REQ-028 Without LEADING_ZERO_BLANK_EN, blank SHALL equal ~enable. All eight digits SHALL then show, including leading zeros.

Verification (REFRESH_DIV=4)
REQ-029 Release reset, enable=1, load 32'h89ABCDEF -> anode cycles FE,FD,...,7F, 4 clk each. hex_sel reads F,E,D,C,B,A,9,8 once first frame boundary passes. frame_done pulses once per 32 clk.
REQ-030 Load 32'h11111111 then load 32'h22222222 mid-frame -> current frame shows the old value unchanged. Next frame shows only 2s, never 1s.
REQ-031 Load coincident with the 7->0 wrap cycle -> new value visible on digit 0 of the very next frame, pending=0.
REQ-032 enable 1->0 at digit 5 -> next cycle anode=8'hFF, blank=1. Re-enable -> digit 0 first, with a full 4-clk slot.
REQ-033 Assert reset_n=0 mid-slot at digit 3 with a pending load -> outputs reach reset values with no clk edge. After release, active=0, displayed digits are 0.
REQ-034 With LEADING_ZERO_BLANK_EN, load 32'h00000A50 -> blank=1 on digits 3..7, blank=0 on digits 0..2. Load 0 -> only digit 0 unblanked, showing 0.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 8-digit multiplexed hex scanner, tear-free buffer.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the top nonzero.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] data_in,
  output logic [7:0]  anode,
  output logic [3:0]  hex_sel,
  output logic        blank,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_tick_cnt;
  logic [2:0]    r_digit_idx;
  logic          r_frame_done;
  logic [7:0]    r_anode;
  logic [3:0]    r_hex_sel;
  logic          r_blank;
  logic [31:0]   r_shadow;
  logic [31:0]   r_active;
  logic          r_pending;

  logic          w_tick;
  logic          w_wrap;
  logic [7:0]    w_anode_nxt;
  logic [3:0]    w_nibble;
  logic          w_blank_nxt;
  logic [31:0]   w_shadow_nxt;
  logic [31:0]   w_active_nxt;
  logic          w_pending_nxt;
  logic          w_take_din;
  logic          w_take_shadow;
  logic          w_capture;

  assign w_tick = enable & (r_tick_cnt == TC);
  assign w_wrap = w_tick & (r_digit_idx == 3'd7);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (!enable || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit_idx  <= 3'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (!enable) begin
        r_digit_idx <= 3'd0;
      end else if (w_tick) begin
        r_digit_idx <= r_digit_idx + 3'd1;
      end
    end
  end

  // Active register only changes at a frame wrap (or while dark),
  // so a frame never mixes two values.
  assign w_take_din    = w_wrap & load;
  assign w_take_shadow = (w_wrap | ~enable) & ~load & r_pending;
  assign w_capture     = load & ~w_wrap;

  always_comb begin
    w_shadow_nxt  = r_shadow;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    if (load) begin
      w_shadow_nxt = data_in;
    end
    unique case (1'b1)
      w_take_din: begin
        w_active_nxt  = data_in;
        w_pending_nxt = 1'b0;
      end
      w_take_shadow: begin
        w_active_nxt  = r_shadow;
        w_pending_nxt = 1'b0;
      end
      w_capture: begin
        w_pending_nxt = 1'b1;
      end
      default: begin
        w_pending_nxt = r_pending;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_shadow  <= w_shadow_nxt;
      r_active  <= w_active_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign w_nibble    = 4'(r_active >> {r_digit_idx, 2'b00});
  assign w_anode_nxt = enable ? ~(8'd1 << r_digit_idx) : 8'hFF;

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] w_msd;

  always_comb begin
    w_msd = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (r_active[4*k +: 4] != 4'd0) begin
        w_msd = 3'(k);
      end
    end
  end

  assign w_blank_nxt = ~enable | (r_digit_idx > w_msd);
`else
  assign w_blank_nxt = ~enable;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_anode   <= 8'hFF;
      r_hex_sel <= 4'd0;
      r_blank   <= 1'b1;
    end else begin
      r_anode   <= w_anode_nxt;
      r_hex_sel <= w_nibble;
      r_blank   <= w_blank_nxt;
    end
  end

  assign anode      = r_anode;
  assign hex_sel    = r_hex_sel;
  assign blank      = r_blank;
  assign digit_idx  = r_digit_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench, REFRESH_DIV=4.
// Expected digit events are queued by stimulus, popped on anode change.
module tb_display_scan_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  anode;
  logic [3:0]  hex_sel;
  logic        blank;
  logic [2:0]  digit_idx;
  logic        frame_done;

  display_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .load       (load),
    .data_in    (data_in),
    .anode      (anode),
    .hex_sel    (hex_sel),
    .blank      (blank),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [7:0] an;
    logic [3:0] hx;
    logic       chk_hx;
    logic       bl;
    int         dwell;
  } exp_t;

  exp_t q[$];
  int   fd_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   last_chg = 0;
  int   dw;
  bit   mon_en = 0;
  logic [7:0] prev_an = 8'hFF;
  exp_t me;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every anode change is one displayed-digit event.
  always @(negedge clk) begin
    if (frame_done) fd_q.push_back(cyc);
    if (anode != prev_an) begin
      if (mon_en) begin
        n_vec++;
        dw = cyc - last_chg;
        if (q.size() == 0) begin
          n_miss++;
          $display("FAIL scan_evt unexpected anode=%h hex=%h", anode, hex_sel);
        end else begin
          me = q.pop_front();
          if (anode != me.an || (me.chk_hx && hex_sel != me.hx) ||
              blank != me.bl || (me.dwell != 0 && dw != me.dwell)) begin
            n_miss++;
            $display("FAIL scan_evt got an=%h hx=%h bl=%b dw=%0d want an=%h hx=%h bl=%b dw=%0d",
                     anode, hex_sel, blank, dw, me.an, me.hx, me.bl, me.dwell);
          end
        end
      end
      last_chg = cyc;
    end
    prev_an = anode;
  end

  function automatic logic exp_blank(input logic [31:0] v, input int k);
    int top = 0;
    for (int j = 0; j < 8; j++)
      if (v[4*j +: 4] != 4'd0) top = j;
    return LZB && (k > top);
  endfunction

  task automatic push_one(input logic [7:0] an, input logic [3:0] hx,
                          input logic ch, input logic bl, input int dwl);
    exp_t e;
    e.an = an; e.hx = hx; e.chk_hx = ch; e.bl = bl; e.dwell = dwl;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [31:0] v, input int first_dwell);
    for (int k = 0; k < 8; k++)
      push_one(~(8'd1 << k), v[4*k +: 4], 1'b1, exp_blank(v, k),
               (k == 0) ? first_dwell : 4);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    @(posedge clk); #1;
    load = 1'b1; data_in = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic sync_frame();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 100);
    if (!frame_done) begin
      n_vec++; n_miss++;
      $display("FAIL sync_frame no frame_done in 100 cycles");
    end
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 150) begin @(posedge clk); n++; end
    if (q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL %s_drain %0d events left after %0d cycles", nm, q.size(), n);
      q.delete();
    end
    mon_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b1; enable = 1'b0; load = 1'b0; data_in = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_anode", anode, 8'hFF);
    chk("rst_blank", blank, 1);
    chk("rst_hex", hex_sel, 0);
    chk("rst_idx", digit_idx, 0);
    chk("rst_fd", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic scan: frame of zeros, then loaded value after the wrap.
    @(posedge clk); #1;
    fd_q.delete();
    push_frame(32'h0, 0);
    push_frame(32'h89ABCDEF, 4);
    mon_en = 1;
    enable = 1'b1; load = 1'b1; data_in = 32'h89ABCDEF;
    @(posedge clk); #1 load = 1'b0;
    drain("scan");
    n = 0;
    while (fd_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
    if (fd_q.size() < 2) chk("frame_pulses", fd_q.size(), 2);
    else chk("frame_period", fd_q[1] - fd_q[0], 32);

    // Two loads mid-frame: current frame untouched, last load wins.
    sync_frame();
    push_frame(32'h89ABCDEF, 4);
    push_frame(32'h22222222, 4);
    mon_en = 1;
    do_load(32'h11111111);
    repeat (5) @(posedge clk);
    do_load(32'h22222222);
    drain("tearfree");

    // Load coincident with the wrap edge.
    sync_frame();
    push_frame(32'h22222222, 4);
    push_frame(32'h13579BDF, 4);
    mon_en = 1;
    repeat (30) @(posedge clk);
    do_load(32'h13579BDF);
    chk("wrap_pending", dut.r_pending, 0);
    drain("wrapload");

    // Disable at digit 5, load while dark, re-enable.
    sync_frame();
    for (int k = 0; k < 6; k++)
      push_one(~(8'd1 << k), 32'h13579BDF >> (4*k), 1'b1, 1'b0, 4);
    push_one(8'hFF, 4'h0, 1'b0, 1'b1, 1);
    push_one(8'hFE, 4'hE, 1'b1, 1'b0, 0);
    push_one(8'hFD, 4'hB, 1'b1, 1'b0, 4);
    mon_en = 1;
    repeat (21) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("dis_idx", digit_idx, 0);
    chk("dis_fd", frame_done, 0);
    fd_q.delete();
    do_load(32'hCAFEBABE);
    repeat (6) @(posedge clk);
    #1;
    chk("dis_no_fd", fd_q.size(), 0);
    chk("dis_anode", anode, 8'hFF);
    enable = 1'b1;
    drain("disable");

    // Async reset mid-slot at digit 3 with a pending load.
    n = 0;
    do begin @(negedge clk); n++; end while (digit_idx != 3'd3 && n < 100);
    chk("reach_digit3", digit_idx, 3);
    do_load(32'h55555555);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_anode", anode, 8'hFF);
    chk("arst_blank", blank, 1);
    chk("arst_hex", hex_sel, 0);
    chk("arst_idx", digit_idx, 0);
    chk("arst_pending", dut.r_pending, 0);
    @(negedge clk);
    @(posedge clk); #1;
    push_frame(32'h0, 0);
    push_frame(32'h0, 4);
    mon_en = 1;
    reset_n = 1'b1;
    drain("postreset");

    // Leading-zero pattern and all-zero value.
    sync_frame();
    push_frame(32'h0, 4);
    push_frame(32'h00000A50, 4);
    mon_en = 1;
    do_load(32'h00000A50);
    drain("lz_a50");
    sync_frame();
    push_frame(32'h00000A50, 4);
    push_frame(32'h0, 4);
    mon_en = 1;
    do_load(32'h0);
    drain("lz_zero");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
